// File: rtl/mux_oht_stream.sv
// mux_oht_stream
//   Stream multiplexer with a one-hot channel select and valid/ready handshake.
//   In IDLE, a one-hot request on `oht` is locked into `sel`. In LOCK, beats from
//   the selected channel pass through one registered output stage. The last beat
//   of the packet (i_lst) releases the lock. The cycle after a last beat is always
//   IDLE, so consecutive packets are separated by at least one bubble.
//
//   Optional feature macro: MUX_OHT_STREAM_ERR_EN
//     Defined   : err becomes a sticky flag. It is set when oht is multi-hot in
//                 IDLE, or when a non-selected channel presents i_vld together
//                 with i_lst while in LOCK. It is cleared only by rst.
//     Undefined : err is tied to 0.
//
// Ports
//   clk    clock
//   rst    synchronous, active-high reset
//   oht    one-hot channel request (WIDTH), sampled only in IDLE
//   i_vld  per-channel valid (WIDTH)
//   i_lst  per-channel last-beat flag (WIDTH)
//   i_dat  per-channel data, channel c in bits [c*DATA_W +: DATA_W]
//   i_rdy  per-channel ready (WIDTH), combinational
//   o_vld  registered output valid
//   o_lst  registered output last
//   o_dat  registered output data (DATA_W)
//   o_rdy  output ready from the sink
//   sel    locked one-hot select, 0 while IDLE
//   err    sticky select error (see macro above)

module mux_oht_stream #(
   parameter int DATA_W = 8,
   parameter int WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        oht,
   input  logic [WIDTH-1:0]        i_vld,
   input  logic [WIDTH-1:0]        i_lst,
   input  logic [WIDTH*DATA_W-1:0] i_dat,
   output logic [WIDTH-1:0]        i_rdy,
   output logic                    o_vld,
   output logic                    o_lst,
   output logic [DATA_W-1:0]       o_dat,
   input  logic                    o_rdy,
   output logic [WIDTH-1:0]        sel,
   output logic                    err
);

   localparam logic [0:0]       IDLE = 1'b0;
   localparam logic [0:0]       LOCK = 1'b1;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [0:0]        state;
   logic              oht_multi;
   logic              oht_one;
   logic              can_load;
   logic              xfer;
   logic [DATA_W-1:0] mux_dat;
   logic              mux_lst;

   // x & (x-1) clears the lowest set bit, so any survivor means two or more bits set.
   assign oht_multi = |(oht & (oht - ONE));
   assign oht_one   = (|oht) & ~oht_multi;

   // The output register can accept a new beat when it is empty or being drained this cycle.
   assign can_load  = ~o_vld | o_rdy;
   assign i_rdy     = (state == LOCK) ? (sel & {WIDTH{can_load}}) : '0;
   assign xfer      = |(i_vld & i_rdy);

   // AND-OR mux: sel is one-hot in LOCK, so at most one channel contributes.
   always_comb begin
      mux_dat = '0;
      mux_lst = 1'b0;
      for (int c = 0; c < WIDTH; c++) begin
         mux_dat = mux_dat | (i_dat[c*DATA_W +: DATA_W] & {DATA_W{sel[c]}});
         mux_lst = mux_lst | (i_lst[c] & sel[c]);
      end
   end

   // Select FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sel   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (oht_one) begin
                  sel   <= oht;
                  state <= LOCK;
               end
            end
            default: begin
               if (xfer && mux_lst) begin
                  sel   <= '0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   // Output register stage; keeps draining in IDLE while the FSM relocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_vld <= 1'b0;
         o_lst <= 1'b0;
         o_dat <= '0;
      end else if (xfer) begin
         o_vld <= 1'b1;
         o_lst <= mux_lst;
         o_dat <= mux_dat;
      end else if (o_vld && o_rdy) begin
         o_vld <= 1'b0;
         o_lst <= 1'b0;
      end
   end

`ifdef MUX_OHT_STREAM_ERR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (((state == IDLE) && oht_multi) ||
                   ((state == LOCK) && (|(i_vld & i_lst & ~sel)))) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_oht_stream.sv
// tb_mux_oht_stream
//   Bench for mux_oht_stream (WIDTH=16, 8-bit data). Channel c beat b carries
//   data 16*c+b. A queue-based model holds the beats each packet should deliver.
//   A negedge monitor collects the beats the sink accepts (o_vld & o_rdy) and
//   checks the handshake properties on every cycle.

module tb_mux_oht_stream;

   localparam int DATA_W = 8;
   localparam int WIDTH  = 16;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [WIDTH-1:0]        oht;
   logic [WIDTH-1:0]        i_vld;
   logic [WIDTH-1:0]        i_lst;
   logic [WIDTH*DATA_W-1:0] i_dat;
   logic [WIDTH-1:0]        i_rdy;
   logic                    o_vld;
   logic                    o_lst;
   logic [DATA_W-1:0]       o_dat;
   logic                    o_rdy;
   logic [WIDTH-1:0]        sel;
   logic                    err;

   int checks = 0;
   int fails  = 0;

   // {lst, dat} beats: expected from the packet definitions, got from the sink side.
   logic [DATA_W:0] exp_q[$];
   logic [DATA_W:0] got_q[$];

   // 0: o_rdy always 1, 1: repeating 1,0,0,1 pattern, 2: random
   int       rdy_mode = 0;
   logic [3:0] rdy_pat = 4'b1001;
   logic [1:0] rdy_idx = 2'd0;

   mux_oht_stream #(.DATA_W(DATA_W), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .oht   (oht),
      .i_vld (i_vld),
      .i_lst (i_lst),
      .i_dat (i_dat),
      .i_rdy (i_rdy),
      .o_vld (o_vld),
      .o_lst (o_lst),
      .o_dat (o_dat),
      .o_rdy (o_rdy),
      .sel   (sel),
      .err   (err)
   );

   always #5 clk = ~clk;

   // Sink ready driver
   initial begin
      o_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: o_rdy = 1'b1;
            1: begin
               o_rdy   = rdy_pat[rdy_idx];
               rdy_idx = rdy_idx + 2'd1;
            end
            default: o_rdy = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Sink monitor and per-cycle protocol checks
   logic            prev_stall = 1'b0;
   logic            prev_rst   = 1'b1;
   logic [DATA_W:0] prev_beat  = '0;

   always @(negedge clk) begin
      if (o_vld && o_rdy) got_q.push_back({o_lst, o_dat});
      checks++;
      if ((i_rdy & ~sel) !== '0) begin
         fails++;
         $display("FAIL unselected_rdy: i_rdy=%h sel=%h, required i_rdy within sel", i_rdy, sel);
      end
      if (o_vld && !o_rdy) begin
         checks++;
         if (i_rdy !== '0) begin
            fails++;
            $display("FAIL stall_rdy: i_rdy=%h during backpressure, required 0", i_rdy);
         end
      end
      if (prev_stall && !prev_rst) begin
         checks++;
         if (o_vld !== 1'b1 || {o_lst, o_dat} !== prev_beat) begin
            fails++;
            $display("FAIL stall_hold: o_vld=%b beat=%h, required o_vld=1 beat=%h",
                     o_vld, {o_lst, o_dat}, prev_beat);
         end
      end
      prev_stall = o_vld && !o_rdy;
      prev_beat  = {o_lst, o_dat};
      prev_rst   = rst;
   end

   // Random activity on the channels that are not being sent
   task automatic drive_noise(input int ch);
      logic [WIDTH-1:0] mask;
      mask  = ~(WIDTH'(1) << ch);
      i_vld = 16'($urandom) & mask;
`ifdef MUX_OHT_STREAM_ERR_EN
      i_lst = '0;
`else
      i_lst = 16'($urandom) & mask;
`endif
      i_dat = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic lock_ch(input int ch);
      logic [WIDTH-1:0] want;
      want = WIDTH'(1) << ch;
      checks++;
      if (sel !== '0) begin
         fails++;
         $display("FAIL pre_lock_sel: sel=%h, required 0", sel);
      end
      oht = want;
      @(posedge clk);
      #1;
      checks++;
      if (sel !== want) begin
         fails++;
         $display("FAIL lock_sel ch%0d: sel=%h, required %h", ch, sel, want);
      end
      oht = '0;
   endtask

   // Offers beats b0..b0+n-1 of channel ch, holding each until it is accepted.
   task automatic send_beats(input int ch, input int b0, input int n,
                             input bit last_en, output int waits);
      logic [DATA_W-1:0] d;
      logic              l;
      logic              done;
      int                cyc;
      waits = 0;
      for (int b = b0; b < b0 + n; b++) begin
         d = 8'(16 * ch + b);
         l = last_en && (b == b0 + n - 1);
         exp_q.push_back({l, d});
         done = 1'b0;
         cyc  = 0;
         while (!done) begin
            drive_noise(ch);
            i_vld[ch] = 1'b1;
            i_lst[ch] = l;
            i_dat[ch*DATA_W +: DATA_W] = d;
            @(negedge clk);
            done = i_rdy[ch];
            @(posedge clk);
            #1;
            if (!done) begin
               waits++;
               cyc++;
               if (cyc > 100) begin
                  checks++;
                  fails++;
                  $display("FAIL accept_timeout ch%0d beat%0d: no i_rdy in 100 cycles, required acceptance", ch, b);
                  i_vld = '0;
                  i_lst = '0;
                  return;
               end
            end
         end
      end
      i_vld = '0;
      i_lst = '0;
   endtask

   task automatic check_sel_idle(input string name);
      checks++;
      if (sel !== '0) begin
         fails++;
         $display("FAIL %s: sel=%h after last beat, required 0", name, sel);
      end
   endtask

   task automatic drain_check(input string name);
      int n;
      logic [DATA_W:0] e;
      logic [DATA_W:0] g;
      n = 0;
      while (got_q.size() < exp_q.size() && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL %s beat_count: got %0d beats, required %0d", name, got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e) begin
            fails++;
            $display("FAIL %s beat: got lst=%b dat=%0d, required lst=%b dat=%0d",
                     name, g[DATA_W], g[DATA_W-1:0], e[DATA_W], e[DATA_W-1:0]);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      oht   = '0;
      i_vld = '0;
      i_lst = '0;
      i_dat = '0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (o_vld !== 1'b0 || o_lst !== 1'b0 || o_dat !== '0 || sel !== '0 ||
          i_rdy !== '0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: o_vld=%b o_lst=%b o_dat=%h sel=%h i_rdy=%h err=%b, required all 0",
                  o_vld, o_lst, o_dat, sel, i_rdy, err);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic;
      int w;
      rdy_mode = 0;
      lock_ch(3);
      send_beats(3, 0, 4, 1'b1, w);
      checks++;
      if (w != 0) begin
         fails++;
         $display("FAIL basic_throughput: %0d stall cycles, required 0", w);
      end
      check_sel_idle("basic_sel_release");
      drain_check("basic");
   endtask

   task automatic test_backpressure;
      int w;
      rdy_mode = 1;
      lock_ch(5);
      send_beats(5, 0, 3, 1'b1, w);
      check_sel_idle("bp_sel_release");
      drain_check("backpressure");
      rdy_mode = 0;
   endtask

   task automatic test_multihot;
      oht   = 16'h0011;
      i_vld = 16'h0011;
      i_lst = '0;
      repeat (3) begin
         @(posedge clk);
         #1;
         checks++;
         if (sel !== '0 || i_rdy !== '0) begin
            fails++;
            $display("FAIL multihot_ignore: sel=%h i_rdy=%h, required 0 and 0", sel, i_rdy);
         end
      end
      checks++;
`ifdef MUX_OHT_STREAM_ERR_EN
      if (err !== 1'b1) begin
         fails++;
         $display("FAIL multihot_err: err=%b, required 1", err);
      end
`else
      if (err !== 1'b0) begin
         fails++;
         $display("FAIL multihot_err: err=%b, required 0", err);
      end
`endif
      oht   = '0;
      i_vld = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      int w;
      rdy_mode = 0;
      lock_ch(2);
      send_beats(2, 0, 1, 1'b0, w);
      oht = 16'h8000;
      send_beats(2, 1, 2, 1'b1, w);
      check_sel_idle("b2b_sel_release");
      @(posedge clk);
      #1;
      checks++;
      if (sel !== 16'h8000) begin
         fails++;
         $display("FAIL b2b_relock: sel=%h, required 8000", sel);
      end
      oht = '0;
      send_beats(15, 0, 3, 1'b1, w);
      check_sel_idle("b2b_sel_release2");
      drain_check("back_to_back");
   endtask

   task automatic test_mid_reset;
      int w;
      rdy_mode = 0;
      lock_ch(7);
      send_beats(7, 0, 2, 1'b0, w);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (o_vld !== 1'b0 || o_lst !== 1'b0 || sel !== '0 || err !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: o_vld=%b o_lst=%b sel=%h err=%b, required all 0",
                  o_vld, o_lst, sel, err);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      drain_check("truncated");
      lock_ch(7);
      send_beats(7, 0, 4, 1'b1, w);
      check_sel_idle("after_reset_sel_release");
      drain_check("after_reset");
   endtask

   task automatic test_random;
      int w;
      int ch;
      int n;
      rdy_mode = 2;
      for (int p = 0; p < 12; p++) begin
         ch = $urandom_range(0, WIDTH - 1);
         n  = $urandom_range(1, 8);
         lock_ch(ch);
         send_beats(ch, 0, n, 1'b1, w);
         check_sel_idle("random_sel_release");
      end
      drain_check("random");
      rdy_mode = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_multihot();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
